// File: rtl/unified_buffer_arbiter.sv
// Arbitrates the single-port unified buffer between compute reads, host writes and
// accumulator writeback: reads have priority, writers alternate, starved writers are forced.
module unified_buffer_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              hw_req_i,
    input  logic [ADDR_W-1:0] hw_addr_i,
    input  logic [DATA_W-1:0] hw_data_i,
    output logic              hw_gnt_o,
    input  logic              wb_req_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              wb_gnt_o,
    output logic              ub_en_o,
    output logic              ub_we_o,
    output logic [ADDR_W-1:0] ub_addr_o,
    output logic [DATA_W-1:0] ub_wdata_o,
    input  logic [DATA_W-1:0] ub_rdata_i,
    output logic              rd_starved_o
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {RR_HW = 1'b0, RR_WB = 1'b1} rr_e;

    rr_e               rr_q, rr_d;
    logic [CNT_W-1:0]  hw_cnt_q, hw_cnt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic              ub_en_q, ub_en_d;
    logic              ub_we_q, ub_we_d;
    logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
    logic [DATA_W-1:0] ub_wdata_q, ub_wdata_d;
    logic              rd_valid_q, rd_valid_d;

    logic rd_gnt, hw_gnt, wb_gnt;
    logic hw_force, wb_force;

    assign hw_force = (STARVE_LIMIT != 0) && (hw_cnt_q == CNT_MAX) && hw_req_i;
    assign wb_force = (STARVE_LIMIT != 0) && (wb_cnt_q == CNT_MAX) && wb_req_i;

    // Grants are held low during reset so every output reads 0 while rst_i is asserted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_gnt = 1'b0;
        hw_gnt = 1'b0;
        wb_gnt = 1'b0;
        if (rst_i) begin
            if (hw_force && wb_force) begin
                hw_gnt = (rr_q == RR_HW);
                wb_gnt = (rr_q == RR_WB);
            end else if (hw_force) begin
                hw_gnt = 1'b1;
            end else if (wb_force) begin
                wb_gnt = 1'b1;
            end else if (rd_req_i) begin
                rd_gnt = 1'b1;
            end else if (hw_req_i && wb_req_i) begin
                hw_gnt = (rr_q == RR_HW);
                wb_gnt = (rr_q == RR_WB);
            end else begin
                hw_gnt = hw_req_i;
                wb_gnt = wb_req_i;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hw_gnt)      rr_d = RR_WB;
        else if (wb_gnt) rr_d = RR_HW;

        // Only denials caused by a read count toward starvation.
        hw_cnt_d = hw_cnt_q;
        if (!hw_req_i || hw_gnt)             hw_cnt_d = '0;
        else if (rd_gnt && hw_cnt_q != CNT_MAX) hw_cnt_d = hw_cnt_q + CNT_W'(1);

        wb_cnt_d = wb_cnt_q;
        if (!wb_req_i || wb_gnt)             wb_cnt_d = '0;
        else if (rd_gnt && wb_cnt_q != CNT_MAX) wb_cnt_d = wb_cnt_q + CNT_W'(1);

        ub_en_d    = rd_gnt | hw_gnt | wb_gnt;
        ub_we_d    = hw_gnt | wb_gnt;
        ub_addr_d  = ub_addr_q;
        ub_wdata_d = ub_wdata_q;
        if (rd_gnt) begin
            ub_addr_d = rd_addr_i;
        end else if (hw_gnt) begin
            ub_addr_d  = hw_addr_i;
            ub_wdata_d = hw_data_i;
        end else if (wb_gnt) begin
            ub_addr_d  = wb_addr_i;
            ub_wdata_d = wb_data_i;
        end

        rd_valid_d = ub_en_q & ~ub_we_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q       <= RR_HW;
            hw_cnt_q   <= '0;
            wb_cnt_q   <= '0;
            ub_en_q    <= 1'b0;
            ub_we_q    <= 1'b0;
            ub_addr_q  <= '0;
            ub_wdata_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            hw_cnt_q   <= hw_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
            ub_en_q    <= ub_en_d;
            ub_we_q    <= ub_we_d;
            ub_addr_q  <= ub_addr_d;
            ub_wdata_q <= ub_wdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_gnt_o     = rd_gnt;
    assign hw_gnt_o     = hw_gnt;
    assign wb_gnt_o     = wb_gnt;
    assign rd_starved_o = rd_req_i & (hw_gnt | wb_gnt);
    assign ub_en_o      = ub_en_q;
    assign ub_we_o      = ub_we_q;
    assign ub_addr_o    = ub_addr_q;
    assign ub_wdata_o   = ub_wdata_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_valid_q ? ub_rdata_i : '0;

endmodule

// File: tb/tb_unified_buffer_arbiter.sv
// Directed bench for unified_buffer_arbiter: one instance with STARVE_LIMIT=8 backed by an
// SRAM model, one with STARVE_LIMIT=0 for the never-force case.
module tb_unified_buffer_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rd_req_i, hw_req_i, wb_req_i;
    logic [ADDR_W-1:0] rd_addr_i, hw_addr_i, wb_addr_i;
    logic [DATA_W-1:0] hw_data_i, wb_data_i;
    logic [DATA_W-1:0] ub_rdata_i;

    logic              rd_gnt_o, rd_valid_o, hw_gnt_o, wb_gnt_o;
    logic              ub_en_o, ub_we_o, rd_starved_o;
    logic [DATA_W-1:0] rd_data_o, ub_wdata_o;
    logic [ADDR_W-1:0] ub_addr_o;

    logic              z_rd_gnt, z_rd_valid, z_hw_gnt, z_wb_gnt;
    logic              z_ub_en, z_ub_we, z_starved;
    logic [DATA_W-1:0] z_rd_data, z_ub_wdata;
    logic [ADDR_W-1:0] z_ub_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    unified_buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .hw_req_i(hw_req_i), .hw_addr_i(hw_addr_i), .hw_data_i(hw_data_i), .hw_gnt_o(hw_gnt_o),
        .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_gnt_o(wb_gnt_o),
        .ub_en_o(ub_en_o), .ub_we_o(ub_we_o), .ub_addr_o(ub_addr_o), .ub_wdata_o(ub_wdata_o),
        .ub_rdata_i(ub_rdata_i), .rd_starved_o(rd_starved_o)
    );

    unified_buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(z_rd_gnt),
        .rd_valid_o(z_rd_valid), .rd_data_o(z_rd_data),
        .hw_req_i(hw_req_i), .hw_addr_i(hw_addr_i), .hw_data_i(hw_data_i), .hw_gnt_o(z_hw_gnt),
        .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_gnt_o(z_wb_gnt),
        .ub_en_o(z_ub_en), .ub_we_o(z_ub_we), .ub_addr_o(z_ub_addr), .ub_wdata_o(z_ub_wdata),
        .ub_rdata_i('0), .rd_starved_o(z_starved)
    );

    // SRAM model: unwritten words read back a fixed preload pattern.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        return (a == 12'h010) ? {16{8'hAA}} : '0;
    endfunction

    always @(posedge clk_i) begin
        if (ub_en_o && ub_we_o) begin
            mem[ub_addr_o]     <= ub_wdata_o;
            written[ub_addr_o] <= 1'b1;
        end else if (ub_en_o) begin
            ub_rdata_i <= written[ub_addr_o] ? mem[ub_addr_o] : preload(ub_addr_o);
        end
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        rd_req_i = 1'b0; hw_req_i = 1'b0; wb_req_i = 1'b0;
        rd_addr_i = '0; hw_addr_i = '0; wb_addr_i = '0;
        hw_data_i = '0; wb_data_i = '0;
        ub_rdata_i = '0;

        // Reset: outputs low even with a read request pending.
        tick();
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        #1;
        check("rst_rd_gnt", rd_gnt_o, 0);
        check("rst_ub_en", ub_en_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_ub_addr", ub_addr_o, 0);
        check("rst_starved", rd_starved_o, 0);

        // Basic read: gnt at N, SRAM read at N+1, data at N+2.
        tick();
        rst_i = 1'b1;
        #1;
        check("rd_gnt_N", rd_gnt_o, 1);
        check("rd_hw_gnt_N", hw_gnt_o, 0);
        tick();
        rd_req_i = 1'b0;
        #1;
        check("rd_ub_en_N1", ub_en_o, 1);
        check("rd_ub_we_N1", ub_we_o, 0);
        check("rd_ub_addr_N1", ub_addr_o, 12'h010);
        check("rd_valid_N1", rd_valid_o, 0);
        tick(); #1;
        check("rd_valid_N2", rd_valid_o, 1);
        check("rd_data_N2", rd_data_o, {16{8'hAA}});
        tick(); #1;
        check("idle_ub_en", ub_en_o, 0);
        check("idle_rd_valid", rd_valid_o, 0);
        check("idle_ub_addr_hold", ub_addr_o, 12'h010);

        // Two writers: alternate starting from hw.
        hw_req_i = 1'b1; hw_addr_i = 12'h030; hw_data_i = {16{8'h11}};
        wb_req_i = 1'b1; wb_addr_i = 12'h040; wb_data_i = {16{8'h22}};
        #1;
        check("rr0_hw", hw_gnt_o, 1);
        check("rr0_wb", wb_gnt_o, 0);
        tick(); #1;
        check("rr1_wb", wb_gnt_o, 1);
        check("rr1_hw", hw_gnt_o, 0);
        check("rr1_ub_we", ub_we_o, 1);
        check("rr1_ub_addr", ub_addr_o, 12'h030);
        check("rr1_ub_wdata", ub_wdata_o, {16{8'h11}});
        tick(); #1;
        check("rr2_hw", hw_gnt_o, 1);
        check("rr2_ub_addr", ub_addr_o, 12'h040);
        tick(); #1;
        check("rr3_wb", wb_gnt_o, 1);
        tick();
        hw_req_i = 1'b0; wb_req_i = 1'b0;
        tick();

        // Starvation: hw forced through on every 9th cycle of continuous reads.
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        hw_req_i = 1'b1; hw_addr_i = 12'h050; hw_data_i = {16{8'h33}};
        for (int i = 0; i < 18; i++) begin
            #1;
            check($sformatf("starve_rd_gnt_%0d", i), rd_gnt_o, (i == 8 || i == 17) ? 0 : 1);
            check($sformatf("starve_hw_gnt_%0d", i), hw_gnt_o, (i == 8 || i == 17) ? 1 : 0);
            check($sformatf("starve_flag_%0d", i), rd_starved_o, (i == 8 || i == 17) ? 1 : 0);
            tick();
        end
        rd_req_i = 1'b0; hw_req_i = 1'b0;
        tick(); tick();

        // STARVE_LIMIT=0: writeback never forced.
        rd_req_i = 1'b1; wb_req_i = 1'b1; wb_addr_i = 12'h060; wb_data_i = {16{8'h44}};
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("nolim_wb_gnt_%0d", i), z_wb_gnt, 0);
            check($sformatf("nolim_rd_gnt_%0d", i), z_rd_gnt, 1);
            check($sformatf("nolim_starved_%0d", i), z_starved, 0);
            tick();
        end
        rd_req_i = 1'b0; wb_req_i = 1'b0;
        tick(); tick();

        // Write then read of the same address on back-to-back cycles.
        hw_req_i = 1'b1; hw_addr_i = 12'h020; hw_data_i = {16{8'h55}};
        #1;
        check("raw_hw_gnt", hw_gnt_o, 1);
        tick();
        hw_req_i = 1'b0; rd_req_i = 1'b1; rd_addr_i = 12'h020;
        #1;
        check("raw_rd_gnt", rd_gnt_o, 1);
        tick();
        rd_req_i = 1'b0;
        #1;
        check("raw_rd_valid_N2", rd_valid_o, 0);
        tick(); #1;
        check("raw_rd_valid_N3", rd_valid_o, 1);
        check("raw_rd_data_N3", rd_data_o, {16{8'h55}});
        tick(); tick();

        // Reset during a read: wb counter pumped to 4 before reset, read in flight discarded.
        rd_req_i = 1'b1; rd_addr_i = 12'h010;
        wb_req_i = 1'b1; wb_addr_i = 12'h070; wb_data_i = {16{8'h66}};
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("pre_rst_rd_gnt_%0d", i), rd_gnt_o, 1);
            tick();
        end
        rst_i = 1'b0; rd_req_i = 1'b0; hw_req_i = 1'b1; hw_addr_i = 12'h080;
        #1;
        check("mid_rst_ub_en", ub_en_o, 0);
        check("mid_rst_hw_gnt", hw_gnt_o, 0);
        check("mid_rst_wb_gnt", wb_gnt_o, 0);
        check("mid_rst_rd_valid", rd_valid_o, 0);
        tick(); #1;
        check("mid_rst_rd_valid2", rd_valid_o, 0);
        tick();
        rst_i = 1'b1;
        #1;
        check("post_rst_hw_first", hw_gnt_o, 1);
        check("post_rst_wb_wait", wb_gnt_o, 0);
        check("post_rst_rd_valid", rd_valid_o, 0);
        tick();
        hw_req_i = 1'b0; rd_req_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("post_rst_wb_gnt_%0d", i), wb_gnt_o, (i == 8) ? 1 : 0);
            if (i == 0) check("post_rst_rd_valid2", rd_valid_o, 0);
            tick();
        end
        rd_req_i = 1'b0; wb_req_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
